// File: rtl/crg_sync_fifo_env_ram_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode encoding and
// default almost-full / almost-empty threshold constants.
package crg_sync_fifo_env_ram_pkg;

  // Values accepted by the FWFT parameter
  localparam int FWFT_REGISTERED = 32'sd0;
  localparam int FWFT_PREFETCH   = 32'sd1;

  // Default thresholds: almost_empty at or below 4 words,
  // almost_full at or above (depth - 4) words
  localparam int DEF_AE_LEVEL  = 32'sd4;
  localparam int DEF_AF_MARGIN = 32'sd4;

  typedef enum logic [0:0] {
    MODE_REGISTERED = 1'b0,
    MODE_PREFETCH   = 1'b1
  } fifo_mode_e;

  // Maps the integer FWFT parameter onto the mode enum; anything that is
  // not the prefetch value falls back to the registered read mode.
  function automatic fifo_mode_e mode_from_param(input int fwft);
    fifo_mode_e mode;
    if (fwft == FWFT_PREFETCH) begin
      mode = MODE_PREFETCH;
    end else begin
      mode = MODE_REGISTERED;
    end
    return mode;
  endfunction

endpackage

// File: rtl/crg_sync_fifo_ram.sv
// Behavioural 1-write / 1-read RAM with per-bit write enable and a one-cycle
// registered read. No reset on purpose so a compiled macro can replace it.
module crg_sync_fifo_ram
  import crg_sync_fifo_env_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int DAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DAT_WIDTH-1:0]  wr_data,
  input  logic [DAT_WIDTH-1:0]  wr_bit_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DAT_WIDTH-1:0]  rd_data
);

  logic [DAT_WIDTH-1:0] mem_r [DEPTH];
  logic [DAT_WIDTH-1:0] rd_data_r;

  // Bit-masked write: disabled bits keep their previous contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= (wr_data & wr_bit_en) | (mem_r[wr_addr] & ~wr_bit_en);
    end
  end

  // Registered read port; output holds when no read is issued
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/crg_sync_fifo_env_ram.sv
// Single-clock FIFO around a 1r1w RAM. Supports any depth (not only powers
// of two), masked writes, registered or first-word-fall-through reads,
// registered status flags and sticky overflow/underflow errors.
module crg_sync_fifo_env_ram
  import crg_sync_fifo_env_ram_pkg::*;
#(
  parameter int PTR_WIDTH      = 8,
  parameter int NUM_OF_ENTRIES = 256,
  parameter int DAT_WIDTH      = 32,
  parameter int FWFT           = FWFT_REGISTERED,
  parameter int AF_LEVEL       = NUM_OF_ENTRIES - DEF_AF_MARGIN,
  parameter int AE_LEVEL       = DEF_AE_LEVEL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_op,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic [DAT_WIDTH-1:0] wr_mask,
  input  logic                 rd_op,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 almost_full,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   entry_used,
  output logic                 wr_full_err,
  output logic                 rd_empty_err,
  input  logic                 err_clr
);

  localparam fifo_mode_e             MODE_C     = mode_from_param(FWFT);
  localparam logic [PTR_WIDTH-1:0]   ZERO_PTR_C = PTR_WIDTH'(1'b0);
  localparam logic [PTR_WIDTH-1:0]   ONE_PTR_C  = PTR_WIDTH'(1'b1);
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR_C = PTR_WIDTH'(NUM_OF_ENTRIES - 32'sd1);
  localparam logic [PTR_WIDTH:0]     ZERO_CNT_C = (PTR_WIDTH+1)'(1'b0);
  localparam logic [PTR_WIDTH:0]     ONE_CNT_C  = (PTR_WIDTH+1)'(1'b1);
  localparam logic [PTR_WIDTH:0]     FULL_CNT_C = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
  localparam logic [PTR_WIDTH:0]     AF_CNT_C   = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]     AE_CNT_C   = (PTR_WIDTH+1)'(AE_LEVEL);
  localparam logic [DAT_WIDTH-1:0]   ZERO_DAT_C = DAT_WIDTH'(1'b0);
  localparam logic [DAT_WIDTH-1:0]   ONES_DAT_C = ~ZERO_DAT_C;

  // Pointer advance with wrap at the last implemented entry, so depths that
  // are not a power of two never touch unused RAM locations.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    logic [PTR_WIDTH-1:0] nxt;
    if (ptr == LAST_PTR_C) begin
      nxt = ZERO_PTR_C;
    end else begin
      nxt = ptr + ONE_PTR_C;
    end
    return nxt;
  endfunction

  logic [PTR_WIDTH-1:0] wr_ptr_r;
  logic [PTR_WIDTH-1:0] rd_ptr_r;
  logic [PTR_WIDTH:0]   entry_used_r;
  logic                 full_r;
  logic                 almost_full_r;
  logic                 empty_r;
  logic                 almost_empty_r;
  logic                 rd_valid_r;
  logic                 data_seen_r;
  logic                 wr_full_err_r;
  logic                 rd_empty_err_r;

  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic                 ram_rd_en_s;
  logic [PTR_WIDTH:0]   ram_cnt_s;
  logic [PTR_WIDTH:0]   entry_used_nxt_s;
  logic                 rd_valid_nxt_s;
  logic                 empty_nxt_s;
  logic                 wr_full_err_nxt_s;
  logic                 rd_empty_err_nxt_s;
  logic [DAT_WIDTH-1:0] ram_wr_data_s;
  logic [DAT_WIDTH-1:0] ram_rd_data_s;

  // Masked-off bits must read back as zero rather than stale RAM contents,
  // so the whole word is written with the mask already applied.
  assign ram_wr_data_s = wr_data & wr_mask;

  // Acceptance, RAM read issue, occupancy and next-state of flags
  always_comb begin
    wr_acc_s       = wr_op && !full_r;
    rd_acc_s       = 1'b0;
    ram_rd_en_s    = 1'b0;
    ram_cnt_s      = entry_used_r;
    rd_valid_nxt_s = rd_valid_r;
    empty_nxt_s    = empty_r;
    case (MODE_C)
      MODE_PREFETCH: begin
        // The RAM output register is the head; words still inside the RAM
        // are the occupancy minus the one being shown.
        rd_acc_s  = rd_op && rd_valid_r;
        ram_cnt_s = entry_used_r - (rd_valid_r ? ONE_CNT_C : ZERO_CNT_C);
        if ((ram_cnt_s != ZERO_CNT_C) && (!rd_valid_r || rd_acc_s)) begin
          ram_rd_en_s = 1'b1;
        end else begin
          ram_rd_en_s = 1'b0;
        end
        if (ram_rd_en_s) begin
          rd_valid_nxt_s = 1'b1;
        end else if (rd_acc_s) begin
          rd_valid_nxt_s = 1'b0;
        end else begin
          rd_valid_nxt_s = rd_valid_r;
        end
      end
      default: begin
        rd_acc_s       = rd_op && !empty_r;
        ram_rd_en_s    = rd_acc_s;
        rd_valid_nxt_s = rd_acc_s;
      end
    endcase

    if (wr_acc_s && !rd_acc_s) begin
      entry_used_nxt_s = entry_used_r + ONE_CNT_C;
    end else if (rd_acc_s && !wr_acc_s) begin
      entry_used_nxt_s = entry_used_r - ONE_CNT_C;
    end else begin
      entry_used_nxt_s = entry_used_r;
    end

    case (MODE_C)
      MODE_PREFETCH: empty_nxt_s = !rd_valid_nxt_s;
      default:       empty_nxt_s = (entry_used_nxt_s == ZERO_CNT_C);
    endcase
  end

  // Sticky error next-state; a new error event wins over a same-cycle clear
  always_comb begin
    if (wr_op && full_r) begin
      wr_full_err_nxt_s = 1'b1;
    end else if (err_clr) begin
      wr_full_err_nxt_s = 1'b0;
    end else begin
      wr_full_err_nxt_s = wr_full_err_r;
    end
    if (rd_op && empty_r) begin
      rd_empty_err_nxt_s = 1'b1;
    end else if (err_clr) begin
      rd_empty_err_nxt_s = 1'b0;
    end else begin
      rd_empty_err_nxt_s = rd_empty_err_r;
    end
  end

  // Write and read pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= ZERO_PTR_C;
      rd_ptr_r <= ZERO_PTR_C;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (ram_rd_en_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Occupancy and status flags, all registered from the next occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_used_r   <= ZERO_CNT_C;
      full_r         <= 1'b0;
      almost_full_r  <= 1'b0;
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b1;
    end else begin
      entry_used_r   <= entry_used_nxt_s;
      full_r         <= (entry_used_nxt_s == FULL_CNT_C);
      almost_full_r  <= (entry_used_nxt_s >= AF_CNT_C);
      empty_r        <= empty_nxt_s;
      almost_empty_r <= (entry_used_nxt_s <= AE_CNT_C);
    end
  end

  // Read-side qualifiers; data_seen_r hides pre-reset RAM output contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_r  <= 1'b0;
      data_seen_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_valid_nxt_s;
      if (ram_rd_en_s) begin
        data_seen_r <= 1'b1;
      end
    end
  end

  // Sticky error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_full_err_r  <= 1'b0;
      rd_empty_err_r <= 1'b0;
    end else begin
      wr_full_err_r  <= wr_full_err_nxt_s;
      rd_empty_err_r <= rd_empty_err_nxt_s;
    end
  end

  crg_sync_fifo_ram #(
    .ADDR_WIDTH (PTR_WIDTH),
    .DEPTH      (NUM_OF_ENTRIES),
    .DAT_WIDTH  (DAT_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_acc_s),
    .wr_addr   (wr_ptr_r),
    .wr_data   (ram_wr_data_s),
    .wr_bit_en (ONES_DAT_C),
    .rd_en     (ram_rd_en_s),
    .rd_addr   (rd_ptr_r),
    .rd_data   (ram_rd_data_s)
  );

  assign rd_data      = data_seen_r ? ram_rd_data_s : ZERO_DAT_C;
  assign rd_valid     = rd_valid_r;
  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign empty        = empty_r;
  assign almost_empty = almost_empty_r;
  assign entry_used   = entry_used_r;
  assign wr_full_err  = wr_full_err_r;
  assign rd_empty_err = rd_empty_err_r;

endmodule

// File: tb/tb_crg_sync_fifo_env_ram.sv
// Bench for crg_sync_fifo_env_ram: a registered-read and a FWFT instance of
// depth 6 share one stimulus stream; each is compared every cycle against a
// queue-based reference model.
module tb_crg_sync_fifo_env_ram;

  localparam int DEPTH = 6;
  localparam int AF0   = 5;
  localparam int AE0   = 1;
  localparam int AF1   = DEPTH - 4;
  localparam int AE1   = 4;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_op;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;
  logic        rd_op;
  logic        err_clr;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        full0, full1, afull0, afull1, empty0, empty1, aempty0, aempty1;
  logic [3:0]  used0, used1;
  logic        wfe0, wfe1, ree0, ree1;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last0;
  bit          val0;
  bit          shown1;
  bit          m_wfe0, m_ree0, m_wfe1, m_ree1;

  always #5 clk = ~clk;

  crg_sync_fifo_env_ram #(
    .PTR_WIDTH(3), .NUM_OF_ENTRIES(DEPTH), .DAT_WIDTH(32), .FWFT(0),
    .AF_LEVEL(AF0), .AE_LEVEL(AE0)
  ) dut0 (
    .clk(clk), .reset(reset), .wr_op(wr_op), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_op(rd_op), .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0),
    .almost_full(afull0), .empty(empty0), .almost_empty(aempty0), .entry_used(used0),
    .wr_full_err(wfe0), .rd_empty_err(ree0), .err_clr(err_clr)
  );

  crg_sync_fifo_env_ram #(
    .PTR_WIDTH(3), .NUM_OF_ENTRIES(DEPTH), .DAT_WIDTH(32), .FWFT(1)
  ) dut1 (
    .clk(clk), .reset(reset), .wr_op(wr_op), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_op(rd_op), .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1),
    .almost_full(afull1), .empty(empty1), .almost_empty(aempty1), .entry_used(used1),
    .wr_full_err(wfe1), .rd_empty_err(ree1), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0  = 32'h0;
    val0   = 1'b0;
    shown1 = 1'b0;
    m_wfe0 = 1'b0; m_ree0 = 1'b0; m_wfe1 = 1'b0; m_ree1 = 1'b0;
  endtask

  // one clock edge of the reference behaviour, using the current inputs
  task automatic model_edge();
    bit          wok0, rok0, wok1, pop1;
    logic [31:0] wd;
    wd = wr_data & wr_mask;
    // registered-read FIFO
    wok0   = wr_op && (q0.size() < DEPTH);
    rok0   = rd_op && (q0.size() > 0);
    m_wfe0 = (wr_op && q0.size() == DEPTH) || (m_wfe0 && !err_clr);
    m_ree0 = (rd_op && q0.size() == 0) || (m_ree0 && !err_clr);
    if (rok0) begin
      last0 = q0.pop_front();
      val0  = 1'b1;
    end else begin
      val0 = 1'b0;
    end
    if (wok0) q0.push_back(wd);
    // FWFT FIFO: a word becomes visible one edge after it is in storage
    wok1   = wr_op && (q1.size() < DEPTH);
    pop1   = rd_op && shown1;
    m_wfe1 = (wr_op && q1.size() == DEPTH) || (m_wfe1 && !err_clr);
    m_ree1 = (rd_op && !shown1) || (m_ree1 && !err_clr);
    if (pop1) void'(q1.pop_front());
    if (!(shown1 && !pop1)) shown1 = (q1.size() > 0);
    if (wok1) q1.push_back(wd);
  endtask

  task automatic check_all();
    chk("used0",   64'(used0),     64'(q0.size()));
    chk("full0",   64'(full0),     64'(q0.size() == DEPTH));
    chk("empty0",  64'(empty0),    64'(q0.size() == 0));
    chk("afull0",  64'(afull0),    64'(q0.size() >= AF0));
    chk("aempty0", 64'(aempty0),   64'(q0.size() <= AE0));
    chk("valid0",  64'(rd_valid0), 64'(val0));
    chk("data0",   64'(rd_data0),  64'(last0));
    chk("wfe0",    64'(wfe0),      64'(m_wfe0));
    chk("ree0",    64'(ree0),      64'(m_ree0));
    chk("used1",   64'(used1),     64'(q1.size()));
    chk("full1",   64'(full1),     64'(q1.size() == DEPTH));
    chk("empty1",  64'(empty1),    64'(!shown1));
    chk("afull1",  64'(afull1),    64'(q1.size() >= AF1));
    chk("aempty1", 64'(aempty1),   64'(q1.size() <= AE1));
    chk("valid1",  64'(rd_valid1), 64'(shown1));
    if (shown1) chk("data1", 64'(rd_data1), 64'(q1[0]));
    chk("wfe1",    64'(wfe1),      64'(m_wfe1));
    chk("ree1",    64'(ree1),      64'(m_ree1));
  endtask

  task automatic cyc(input bit w, input logic [31:0] d, input logic [31:0] m,
                     input bit r, input bit c);
    wr_op = w; wr_data = d; wr_mask = m; rd_op = r; err_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_op = 1'b0; wr_data = 32'h0; wr_mask = ONES; rd_op = 1'b0; err_clr = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("rst_data1", 64'(rd_data1), 64'h0);
    reset = 1'b0;

    // fill to full, seventh write overflows
    for (int i = 1; i <= 7; i++) cyc(1'b1, 32'(i), ONES, 1'b0, 1'b0);
    idle(); idle();
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);
    // drain, last read underflows
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, ONES, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);

    // masked write
    cyc(1'b1, 32'hDEAD_BEEF, 32'h0000_FFFF, 1'b0, 1'b0);
    idle(); idle();
    cyc(1'b0, 32'h0, ONES, 1'b1, 1'b0);
    idle();

    // full with simultaneous read and write, then clear, same-cycle set wins
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'hA0 + 32'(i), ONES, 1'b0, 1'b0);
    idle(); idle();
    cyc(1'b1, 32'hBAD, ONES, 1'b1, 1'b0);
    idle();
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);
    idle();
    cyc(1'b1, 32'h55, ONES, 1'b0, 1'b0);
    cyc(1'b1, 32'h66, ONES, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, ONES, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);

    // FWFT latency and back-to-back pops
    cyc(1'b1, 32'hA5, ONES, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hB0 + 32'(i), ONES, 1'b0, 1'b0);
    idle(); idle();
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, ONES, 1'b1, 1'b0);
    idle(); idle();
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);

    // interleaved write/read pairs across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), ONES, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, ONES, 1'b1, 1'b0);
    end
    idle(); idle();
    cyc(1'b0, 32'h0, ONES, 1'b1, 1'b1);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d, m;
      d = $urandom;
      m = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ONES;
      cyc(1'($urandom_range(0, 1)), d, m, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) == 0));
    end

    // reset with words in flight
    cyc(1'b0, 32'h0, ONES, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + 32'(i), ONES, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("mid_rst_data1", 64'(rd_data1), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    cyc(1'b1, 32'h5A5A_0F0F, ONES, 1'b0, 1'b0);
    idle(); idle();
    cyc(1'b0, 32'h0, ONES, 1'b1, 1'b0);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crg_sync_fifo_env_ram.md
CRG_SYNC_FIFO_ENV_RAM -- requirements
Module: crg_sync_fifo_env_ram

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 8, RAM address width.
REQ-002 SHALL have parameter NUM_OF_ENTRIES, default 256, depth; any value in 2..2^PTR_WIDTH, not necessarily a power of two.
REQ-003 SHALL have parameter DAT_WIDTH, default 32, data width.
REQ-004 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-005 SHALL have parameters AF_LEVEL, default NUM_OF_ENTRIES-4, and AE_LEVEL, default 4, the almost-full and almost-empty thresholds.
REQ-006 clk  in  1  single clock for all logic; one clock domain only.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 wr_op  in  1  write request; wr_data  in  DAT_WIDTH  write data; wr_mask  in  DAT_WIDTH  bit enable.
REQ-009 rd_op  in  1  read request (pop).
REQ-010 rd_data  out  DAT_WIDTH  read data; rd_valid  out  1  rd_data qualifier.
REQ-011 full, almost_full, empty, almost_empty  out  1 each  registered status flags.
REQ-012 entry_used  out  PTR_WIDTH+1  occupancy; wr_full_err, rd_empty_err  out  1 each  sticky errors; err_clr  in  1  clears both errors.

Function
REQ-013 Write accepted iff wr_op && !full; the stored word = wr_data & wr_mask (masked-off bits stored as 0).
REQ-014 Read accepted iff rd_op && !empty.
REQ-015 Write and read pointers increment on acceptance and wrap from NUM_OF_ENTRIES-1 to 0.
REQ-016 entry_used: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted; updates the cycle after acceptance.
REQ-017 full = (entry_used==NUM_OF_ENTRIES); almost_full = (entry_used>=AF_LEVEL); almost_empty = (entry_used<=AE_LEVEL).
REQ-018 Simultaneous rd_op and wr_op when full: the read is accepted, the write is rejected, and wr_full_err is set; flags are not bypassed combinationally.
REQ-019 Simultaneous wr_op and rd_op when empty (FWFT=0): the write is accepted, the read is rejected, and rd_empty_err is set.
REQ-020 FWFT=0: empty = (entry_used==0); data of a read accepted at cycle N appears on rd_data at N+1, with rd_valid=1 for exactly that cycle; rd_data otherwise holds its last value.
REQ-021 FWFT=1: a prefetch output register holds the head word; rd_valid=1 whenever rd_data is the head; empty = !rd_valid.
REQ-022 FWFT=1: a word written at cycle N into an empty FIFO shows rd_valid=1 at N+2.
REQ-023 FWFT=1: with rd_op and more entries available, the next head is shown on the following cycle with no bubble; entry_used includes the prefetched word.
REQ-024 Errors are sticky until err_clr; if an error event and err_clr occur in the same cycle, the set wins.
REQ-025 RAM: 1 write port and 1 read port, read latency 1 cycle; read and write of the same address in the same cycle are impossible by construction (only possible when empty or full, and the flags block it).

Reset
REQ-026 Reset asynchronously forces: pointers=0, entry_used=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, wr_full_err=0, rd_empty_err=0.
REQ-027 Reset asserted mid-operation discards all contents; RAM contents are not cleared and are never visible after reset.
REQ-028 Normal operation begins on the first clk edge after reset deasserts.

Structure
REQ-029 A shared package SHALL hold the FIFO mode encoding (FWFT constants) and the default threshold constants.
REQ-030 One sub-module, crg_sync_fifo_ram, SHALL be the behavioural 1r1w masked RAM (NUM_OF_ENTRIES x DAT_WIDTH) and be replaceable by a compiled macro; control logic stays in the top module.

Verification
REQ-031 NUM_OF_ENTRIES=6, FWFT=0: write 6 words 0x1..0x6 -> full=1 and entry_used=6; a 7th write sets wr_full_err and data is unchanged; read 6 words -> 0x1..0x6 in order, empty=1.
REQ-032 Non-power-of-two wrap, depth 6: 20 interleaved write/read pairs -> data in order, pointers wrap at 5->0, no errors.
REQ-033 FWFT=1: write 0xA5 at cycle N into empty FIFO -> rd_valid=1 and rd_data=0xA5 at N+2; back-to-back rd_op over 4 words -> 4 consecutive valid cycles.
REQ-034 Full FIFO with simultaneous rd_op+wr_op -> one word popped, write rejected, wr_full_err=1, entry_used=5; assert err_clr -> wr_full_err=0 next cycle.
REQ-035 wr_mask=0x0000FFFF, wr_data=0xDEADBEEF -> read returns 0x0000BEEF.
REQ-036 Assert reset with 3 entries in flight -> all outputs at reset values asynchronously; after release, empty=1 and a new write/read round-trips correctly.
